id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register of the rv32i core; sits directly upstream of the ALU and drives its `src_a`, `src_b` and `instr` inputs. It holds one decoded instruction under a valid/ready handshake and resolves operands combinationally on its output:

- applies MEM- and WB-stage forwarding;
- selects PC or immediate operands;
- inserts bubbles on load-use hazards.

It also carries destination and store-data fields to the EX/MEM stage.

## Interface
- `XLEN`, 32 (from `rv32i_pkg`): datapath width
- `RAW`, 5: register address width
- `clk` input 1: clock, rising edge
- `rst` input 1: synchronous reset, active-high
- `flush` input 1: discard held and incoming instruction (branch/jump redirect)
- `in_valid` input 1: decode presents an instruction
- `in_ready` output 1: stage accepts this cycle
- `in_pc` input XLEN: instruction PC
- `in_rs1_addr`, `in_rs2_addr` input RAW: source register addresses
- `in_rs1_data`, `in_rs2_data` input XLEN: register file read data
- `in_imm` input XLEN: sign-extended immediate
- `in_rd_addr` input RAW: destination register
- `in_reg_write` input 1: instruction writes `rd`
- `in_alu_instr` input 4: ALU opcode (0000 ADD … 1111 MOD)
- `in_a_pc` input 1: src_a = PC instead of rs1
- `in_b_imm` input 1: src_b = immediate instead of rs2
- `fwd_mem_valid`, `fwd_mem_load` input 1: MEM stage holds a register-writing instruction / that instruction is a load
- `fwd_mem_rd` input RAW; `fwd_mem_data` input XLEN: MEM destination and result
- `fwd_wb_valid` input 1; `fwd_wb_rd` input RAW; `fwd_wb_data` input XLEN: WB destination and result
- `out_valid` output 1: operands are final and consumable
- `out_ready` input 1: EX/MEM accepts
- `out_src_a`, `out_src_b` output XLEN: ALU operands
- `out_alu_instr` output 4: ALU opcode
- `out_rs2_data` output XLEN: forwarded rs2 (store data)
- `out_pc` output XLEN; `out_rd_addr` output RAW; `out_reg_write` output 1: passthrough fields

## Operation
- **Storage:** one entry: `valid_q` plus registered copies of all `in_*` fields.

**Forwarding** (combinational, per source `s`):
- Priority is MEM, then WB, then stored data.
- MEM match: `fwd_mem_valid && fwd_mem_rd == s_addr && s_addr != 0 && !fwd_mem_load`.
- WB match: `fwd_wb_valid && fwd_wb_rd == s_addr && s_addr != 0`.
- Address 0 never forwards. Its stored data is passed unchanged (the register file returns 0).

**Hazard:**
- `hazard = valid_q && fwd_mem_valid && fwd_mem_load && fwd_mem_rd != 0 && (fwd_mem_rd == rs1_addr_q || fwd_mem_rd == rs2_addr_q)`.
- The address comparison applies regardless of `a_pc`/`b_imm`; conservative bubbles are accepted.

**Operand select:**
- `out_src_a = a_pc_q ? pc_q : fwd_rs1`.
- `out_src_b = b_imm_q ? imm_q : fwd_rs2`.
- `out_rs2_data = fwd_rs2`.

**Handshake:**
- `out_valid = valid_q && !hazard`.
- `out_fire = out_valid && out_ready`.
- `in_ready = !rst && (flush || !valid_q || out_fire)`. This is a combinational path from `out_ready`.

**Capture** (`in_valid && in_ready && !flush`):
- Load all fields.
- Set `valid_q = 1`.

**Consume without capture** (`out_fire` and no capture):
- `valid_q = 0`.

**Hold refresh:**
- Applies while `valid_q` and not `out_fire`.
- Each cycle, stored rs1/rs2 data are overwritten with WB-forwarded data on a WB match.
- This preserves values produced by instructions that retire during a stall.
- A MEM-forwarded value is picked up later via WB.

**Flush:**
- Next edge `valid_q = 0`.
- Incoming instruction is discarded.
- Flush overrides capture and consume.
- `out_valid` remains as computed this cycle. The downstream stage gates its own flush.

**Reset:**
- All registers clear to 0, so `valid_q = 0` and `alu_instr = 0000` (ADD).
- Outputs after reset: `out_valid = 0`, `in_ready = 0` while `rst` is high, all data outputs 0.
- Reset mid-stall drops the held entry.

## Timing
- Latency: 1 cycle from capture edge to `out_valid` (absent hazard).
- Throughput: 1 instruction/cycle with `out_ready = 1`. Simultaneous consume and capture is a back-to-back fill.
- Load-use: exactly one bubble while the load sits in MEM. `out_valid` rises in the next cycle, with the load data via WB forward.
- Operand outputs are combinational from registers and forwarding inputs. They are valid in the same cycle as `out_valid`.
- Data outputs while `out_valid = 0` are don't-care, except after reset (0).

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid = 1` -> `in_ready = 0`, `out_valid = 0`, `out_src_a = out_src_b = 0`. Release, present ADD x3,x1,x2 (x1 = 5, x2 = 7) -> next cycle `out_valid = 1`, src_a = 5, src_b = 7, opcode 0000.
- **Forward priority:** held `rs1 = x4`; MEM rd = 4, data 0x11; WB rd = 4, data 0x22 -> src_a = 0x11. Drop MEM -> src_a = 0x22. Set rs1 = x0 with both matching rd = 0 -> src_a = stored value 0.
- **Load-use:** `fwd_mem_load = 1`, rd = 6, instruction reads x6 -> `out_valid = 0` one cycle, `in_ready = 0`. Next cycle WB rd = 6, data 0xDEAD -> `out_valid = 1`, src = 0xDEAD.
- **Stall refresh:** `out_ready = 0` for 3 cycles; WB rd = 2, data 9 pulses in cycle 1 only -> after `out_ready = 1`, src_b = 9, not the stale value.
- **Imm/PC select and flush:** AUIPC-style (`a_pc = 1`, `b_imm = 1`, pc 0x100, imm 0x1000) -> src_a = 0x100, src_b = 0x1000. Assert `flush` with `in_valid = 1` in the same cycle -> next cycle `out_valid = 0`, the new instruction is not captured.
- **Back-to-back:** 4 instructions with `in_valid` and `out_ready` constantly 1 -> 4 consecutive `out_fire` cycles, order preserved.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry valid/ready stage feeding the ALU, with MEM/WB forwarding,
// PC/immediate operand select and load-use bubble insertion. Operands are combinational from state.
package rv32i_pkg;
  localparam int XLEN = 32;
endpackage

module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RAW-1:0]  in_rs1_addr,
  input  logic [RAW-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RAW-1:0]  in_rd_addr,
  input  logic            in_reg_write,
  input  logic [3:0]      in_alu_instr,
  input  logic            in_a_pc,
  input  logic            in_b_imm,
  input  logic            fwd_mem_valid,
  input  logic            fwd_mem_load,
  input  logic [RAW-1:0]  fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [RAW-1:0]  fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_src_a,
  output logic [XLEN-1:0] out_src_b,
  output logic [3:0]      out_alu_instr,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_pc,
  output logic [RAW-1:0]  out_rd_addr,
  output logic            out_reg_write
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RAW-1:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic            reg_write_q, a_pc_q, b_imm_q;
  logic [3:0]      alu_instr_q;

  logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            hazard, out_fire, capture;

  // Loads cannot forward from MEM; their data is not ready until WB.
  assign mem_hit1 = fwd_mem_valid && !fwd_mem_load && (fwd_mem_rd == rs1_addr_q) && (rs1_addr_q != '0);
  assign mem_hit2 = fwd_mem_valid && !fwd_mem_load && (fwd_mem_rd == rs2_addr_q) && (rs2_addr_q != '0);
  assign wb_hit1  = fwd_wb_valid && (fwd_wb_rd == rs1_addr_q) && (rs1_addr_q != '0);
  assign wb_hit2  = fwd_wb_valid && (fwd_wb_rd == rs2_addr_q) && (rs2_addr_q != '0);

  assign fwd_rs1 = mem_hit1 ? fwd_mem_data : (wb_hit1 ? fwd_wb_data : rs1_data_q);
  assign fwd_rs2 = mem_hit2 ? fwd_mem_data : (wb_hit2 ? fwd_wb_data : rs2_data_q);

  assign hazard = valid_q && fwd_mem_valid && fwd_mem_load && (fwd_mem_rd != '0) &&
                  ((fwd_mem_rd == rs1_addr_q) || (fwd_mem_rd == rs2_addr_q));

  assign out_valid = valid_q && !hazard;
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !rst && (flush || !valid_q || out_fire);
  assign capture   = in_valid && in_ready && !flush;

  assign out_src_a     = a_pc_q ? pc_q : fwd_rs1;
  assign out_src_b     = b_imm_q ? imm_q : fwd_rs2;
  assign out_rs2_data  = fwd_rs2;
  assign out_alu_instr = alu_instr_q;
  assign out_pc        = pc_q;
  assign out_rd_addr   = rd_addr_q;
  assign out_reg_write = reg_write_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      alu_instr_q <= 4'b0000;
      a_pc_q      <= 1'b0;
      b_imm_q     <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      pc_q        <= in_pc;
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rs1_data_q  <= in_rs1_data;
      rs2_data_q  <= in_rs2_data;
      imm_q       <= in_imm;
      rd_addr_q   <= in_rd_addr;
      reg_write_q <= in_reg_write;
      alu_instr_q <= in_alu_instr;
      a_pc_q      <= in_a_pc;
      b_imm_q     <= in_b_imm;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Producers retiring through WB during a stall would otherwise be lost.
      if (wb_hit1) rs1_data_q <= fwd_wb_data;
      if (wb_hit2) rs2_data_q <= fwd_wb_data;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: inputs driven 1ns after posedge, outputs sampled 1ns later.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_reg_write, in_a_pc, in_b_imm;
  logic [3:0]  in_alu_instr;
  logic        fwd_mem_valid, fwd_mem_load, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready, out_reg_write;
  logic [31:0] out_src_a, out_src_b, out_rs2_data, out_pc;
  logic [3:0]  out_alu_instr;
  logic [4:0]  out_rd_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_alu_instr(in_alu_instr),
    .in_a_pc(in_a_pc), .in_b_imm(in_b_imm),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_load(fwd_mem_load), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_alu_instr(out_alu_instr),
    .out_rs2_data(out_rs2_data), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write)
  );

  task cyc();
    @(posedge clk);
    #1;
  endtask

  task clear_fwd();
    fwd_mem_valid = 0; fwd_mem_load = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task present(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
               input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
               input logic [4:0] rd, input logic [3:0] op, input logic apc, input logic bimm);
    in_valid = 1; in_pc = pc; in_rs1_addr = rs1a; in_rs1_data = rs1d;
    in_rs2_addr = rs2a; in_rs2_data = rs2d; in_imm = imm; in_rd_addr = rd;
    in_reg_write = 1; in_alu_instr = op; in_a_pc = apc; in_b_imm = bimm;
  endtask

  task test_reset();
    rst = 1; flush = 0; out_ready = 1; clear_fwd();
    present(32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 4'b0000, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_src_a !== 32'd0) begin n_err++; $display("FAIL reset_src_a: got %h want 0", out_src_a); end
      n_cmp++; if (out_src_b !== 32'd0) begin n_err++; $display("FAIL reset_src_b: got %h want 0", out_src_b); end
    end
    rst = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    cyc();
    in_valid = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_src_a !== 32'd5) begin n_err++; $display("FAIL add_src_a: got %h want 5", out_src_a); end
    n_cmp++; if (out_src_b !== 32'd7) begin n_err++; $display("FAIL add_src_b: got %h want 7", out_src_b); end
    n_cmp++; if (out_alu_instr !== 4'b0000) begin n_err++; $display("FAIL add_op: got %b want 0000", out_alu_instr); end
    n_cmp++; if (out_rd_addr !== 5'd3) begin n_err++; $display("FAIL add_rd: got %0d want 3", out_rd_addr); end
    cyc();
  endtask

  task test_forward_priority();
    out_ready = 0;
    present(32'h4, 5'd4, 32'h77, 5'd0, 32'h0, 32'h0, 5'd5, 4'b0001, 0, 0);
    cyc();
    in_valid = 0;
    fwd_mem_valid = 1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h11;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h22;
    #1;
    n_cmp++; if (out_src_a !== 32'h11) begin n_err++; $display("FAIL fwd_mem_prio: got %h want 11", out_src_a); end
    fwd_mem_valid = 0;
    #1;
    n_cmp++; if (out_src_a !== 32'h22) begin n_err++; $display("FAIL fwd_wb: got %h want 22", out_src_a); end
    // Drain and capture an x0-sourced instruction in the same cycle.
    out_ready = 1; clear_fwd();
    present(32'h8, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd6, 4'b0000, 0, 0);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fwd_refill_ready: got %b want 1", in_ready); end
    cyc();
    in_valid = 0; out_ready = 0;
    fwd_mem_valid = 1; fwd_mem_load = 1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h11;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h22;
    #1;
    n_cmp++; if (out_src_a !== 32'h0) begin n_err++; $display("FAIL fwd_x0: got %h want 0", out_src_a); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL x0_load_no_hazard: got %b want 1", out_valid); end
    fwd_mem_load = 0;
    #1;
    n_cmp++; if (out_src_a !== 32'h0) begin n_err++; $display("FAIL fwd_x0_mem: got %h want 0", out_src_a); end
    out_ready = 1; clear_fwd();
    cyc();
  endtask

  task test_load_use();
    out_ready = 1;
    present(32'hC, 5'd6, 32'h55, 5'd6, 32'h55, 32'h0, 5'd7, 4'b0000, 0, 0);
    cyc();
    in_valid = 0;
    fwd_mem_valid = 1; fwd_mem_load = 1; fwd_mem_rd = 5'd6; fwd_mem_data = 32'h99;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_bubble_ready: got %b want 0", in_ready); end
    cyc();
    clear_fwd();
    fwd_wb_valid = 1; fwd_wb_rd = 5'd6; fwd_wb_data = 32'hDEAD;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lu_release_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_src_a !== 32'hDEAD) begin n_err++; $display("FAIL lu_src_a: got %h want dead", out_src_a); end
    n_cmp++; if (out_src_b !== 32'hDEAD) begin n_err++; $display("FAIL lu_src_b: got %h want dead", out_src_b); end
    n_cmp++; if (out_rs2_data !== 32'hDEAD) begin n_err++; $display("FAIL lu_rs2_data: got %h want dead", out_rs2_data); end
    cyc();
    clear_fwd();
  endtask

  task test_stall_refresh();
    out_ready = 0;
    present(32'h10, 5'd1, 32'd1, 5'd2, 32'd3, 32'h0, 5'd8, 4'b0000, 0, 0);
    cyc();
    in_valid = 0;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd2; fwd_wb_data = 32'd9;
    #1;
    n_cmp++; if (out_src_b !== 32'd9) begin n_err++; $display("FAIL stall_c1_src_b: got %0d want 9", out_src_b); end
    cyc();
    clear_fwd();
    #1;
    n_cmp++; if (out_src_b !== 32'd9) begin n_err++; $display("FAIL stall_c2_src_b: got %0d want 9", out_src_b); end
    cyc();
    out_ready = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_release_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_src_b !== 32'd9) begin n_err++; $display("FAIL stall_release_src_b: got %0d want 9", out_src_b); end
    n_cmp++; if (out_src_a !== 32'd1) begin n_err++; $display("FAIL stall_release_src_a: got %0d want 1", out_src_a); end
    cyc();
  endtask

  task test_imm_pc_flush();
    out_ready = 0;
    present(32'h100, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 32'h1000, 5'd9, 4'b0000, 1, 1);
    cyc();
    in_valid = 0;
    #1;
    n_cmp++; if (out_src_a !== 32'h100) begin n_err++; $display("FAIL auipc_src_a: got %h want 100", out_src_a); end
    n_cmp++; if (out_src_b !== 32'h1000) begin n_err++; $display("FAIL auipc_src_b: got %h want 1000", out_src_b); end
    n_cmp++; if (out_rs2_data !== 32'hBBBB) begin n_err++; $display("FAIL auipc_rs2_data: got %h want bbbb", out_rs2_data); end
    present(32'h200, 5'd3, 32'h1, 5'd4, 32'h2, 32'h0, 5'd10, 4'b0010, 0, 0);
    flush = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    cyc();
    flush = 0; in_valid = 0; out_ready = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid_later: got %b want 0", out_valid); end
  endtask

  task test_back_to_back();
    logic [31:0] pc;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'h40 + 32'(4 * k);
      present(pc, 5'(k + 1), 32'h100 + 32'(k), 5'd0, 32'h0, 32'h0, 5'(k + 11), 4'(k), 0, 0);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", k, in_ready); end
      if (k > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_%0d: got %b want 1", k, out_valid); end
        n_cmp++; if (out_pc !== pc - 32'd4) begin n_err++; $display("FAIL b2b_pc_%0d: got %h want %h", k, out_pc, pc - 32'd4); end
        n_cmp++; if (out_src_a !== 32'h100 + 32'(k - 1)) begin n_err++; $display("FAIL b2b_src_a_%0d: got %h want %h", k, out_src_a, 32'h100 + 32'(k - 1)); end
      end
      cyc();
    end
    in_valid = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_last_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h4C) begin n_err++; $display("FAIL b2b_last_pc: got %h want 4c", out_pc); end
    n_cmp++; if (out_alu_instr !== 4'd3) begin n_err++; $display("FAIL b2b_last_op: got %0d want 3", out_alu_instr); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_load_use();
    test_stall_refresh();
    test_imm_pc_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
